// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate stage: FSM encoding and parameter checks.
package mac_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // The accumulator must hold a full product without truncation.
    function automatic bit acc_width_ok(input int unsigned acc_w, input int unsigned n,
                                        input int unsigned m);
        return acc_w >= (n + m);
    endfunction

endpackage

// File: rtl/mac_accumulator_array_mul.sv
// Combinational N x M multiplier, signed (k=1) or unsigned (k=0), full N+M-bit product.
module mac_accumulator_array_mul #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
) (
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    input  logic           k,
    output logic [N+M-1:0] prod
);

    localparam int unsigned P_W = N + M;

    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] b_ext;

    // Extending both operands to the product width makes the low P_W bits of the
    // product correct for both signed and unsigned operands.
    always_comb begin
        a_ext = P_W'(a);
        b_ext = P_W'(b);
        if (k) begin
            a_ext = P_W'($signed(a));
            b_ext = P_W'($signed(b));
        end
        prod = a_ext * b_ext;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Sequential multiply-accumulate: LEN operand pairs per frame, one term per cycle,
// dot product presented on a valid/ready output with a sticky per-frame overflow flag.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     num1,
    input  logic [M-1:0]     num2,
    input  logic             k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int unsigned P_W   = N + M;
    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    generate
        if (!acc_width_ok(ACC_W, N, M)) begin : g_acc_w_err
            $error("mac_accumulator: ACC_W must be >= N+M");
        end
        if (LEN < 1) begin : g_len_err
            $error("mac_accumulator: LEN must be >= 1");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     op1_q;
    logic [M-1:0]     op2_q;
    logic             pipe_v_q;
    logic             pipe_last_q;
    logic             pipe_first_q;
    logic             frame_k_q;
    logic [CNT_W-1:0] count_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_run_q;

    logic             accept;
    logic             term_last;
    logic             term_first;
    logic [P_W-1:0]   prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_full;
    logic [ACC_W-1:0] sum_low;
    logic             carry_in_msb;
    logic             carry_out_msb;
    logic             add_ovf;
    logic             ovf_next;

    mac_accumulator_array_mul #(
        .N (N),
        .M (M)
    ) u_array_mul (
        .a    (op1_q),
        .b    (op2_q),
        .k    (frame_k_q),
        .prod (prod)
    );

    assign accept     = in_valid && in_ready;
    assign term_last  = (count_q == LAST_IDX);
    assign term_first = (count_q == '0);

    // Accumulator datapath with MSB carry extraction for overflow detection.
    always_comb begin
        prod_ext      = frame_k_q ? ACC_W'($signed(prod)) : ACC_W'(prod);
        sum_full      = {1'b0, acc_q} + {1'b0, prod_ext};
        sum_low       = {1'b0, acc_q[ACC_W-2:0]} + {1'b0, prod_ext[ACC_W-2:0]};
        carry_out_msb = sum_full[ACC_W];
        carry_in_msb  = sum_low[ACC_W-1];
        add_ovf       = frame_k_q ? (carry_in_msb ^ carry_out_msb) : carry_out_msb;
        ovf_next      = (pipe_first_q ? 1'b0 : ovf_run_q) | add_ovf;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = !(pipe_v_q && pipe_last_q);
                if (pipe_v_q && pipe_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            op1_q        <= '0;
            op2_q        <= '0;
            pipe_v_q     <= 1'b0;
            pipe_last_q  <= 1'b0;
            pipe_first_q <= 1'b0;
            frame_k_q    <= 1'b0;
            count_q      <= '0;
            acc_q        <= '0;
            ovf_run_q    <= 1'b0;
            acc_out      <= '0;
            overflow     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pipe_v_q <= accept;
            if (accept) begin
                op1_q        <= num1;
                op2_q        <= num2;
                pipe_last_q  <= term_last;
                pipe_first_q <= term_first;
                count_q      <= term_last ? '0 : count_q + CNT_W'(1);
                if (term_first) begin
                    frame_k_q <= k;
                end
            end
            // The final add of a frame lands in the result regs and clears the running sum.
            if (pipe_v_q) begin
                if (pipe_last_q) begin
                    acc_out   <= sum_full[ACC_W-1:0];
                    overflow  <= ovf_next;
                    acc_q     <= '0;
                    ovf_run_q <= 1'b0;
                end else begin
                    acc_q     <= sum_full[ACC_W-1:0];
                    ovf_run_q <= ovf_next;
                end
            end
        end
    end

endmodule
